// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: control bit positions,
// EX/MEM payload width and the stage occupancy state.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;

  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned EX_MEM_DATA_W = 69;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stage_state_e;

  function automatic logic [1:0] state_occupancy(stage_state_e s);
    logic [1:0] occ;
    unique case (s)
      StOne:   occ = 2'd1;
      StTwo:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register entry: valid bit plus control and data payload.
// Clear wins over load; payload registers only change on a load.
module pipe_slot #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 69
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register with valid/ready handshake, optional skid entry,
// synchronous flush and masking of control bits while the stage is empty.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_DATA_W,
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  stage_state_e state_q, state_d;
  logic         ready_q;
  logic [1:0]   occ_q;

  logic acc, pop;
  logic main_load, main_clear, skid_load, skid_clear;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_src_data;

  // Registered ready in skid mode keeps out_ready_i off the upstream timing path.
  assign in_ready_o = (SKID != 0) ? ready_q : (!main_valid || out_ready_i);
  assign acc        = in_valid_i && in_ready_o;
  assign pop        = main_valid && out_ready_i;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush_i) begin
      state_d    = StEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d   = StOne;
            main_load = 1'b1;
          end
        end
        StOne: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc && (SKID != 0)) begin
            state_d   = StTwo;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d    = StEmpty;
            main_clear = 1'b1;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d    = StOne;
            main_load  = 1'b1;
            skid_clear = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != StTwo);
      occ_q   <= state_occupancy(state_d);
    end
  end

  // Main refills from the skid entry whenever the skid entry is occupied.
  assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl_i;
  assign main_src_data = skid_valid ? skid_data : in_data_i;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_src_ctrl),
    .data_i  (main_src_data),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign unused_skid = skid_load ^ skid_clear;
    assign skid_valid  = 1'b0;
    assign skid_ctrl   = '0;
    assign skid_data   = '0;
  end

  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data_o  = main_data;
  assign occupancy_o = occ_q;

  occ_matches_entries: assert property (@(posedge clk_i) disable iff (!rst_i)
    occupancy_o == ({1'b0, main_valid} + {1'b0, skid_valid}));

  single_entry_limit: assert property (@(posedge clk_i) disable iff (!rst_i)
    !((SKID == 0) && (occupancy_o > 2'd1)));

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised pipeline stage register that replaces the fixed-field, stall-only inter-stage latch between execute and memory.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and bubble-safe control masking.
- Carries a generic control vector and a generic data vector.
- Sits between any two CPU pipeline stages. Typical use is EX to MEM, with data = {ALU result, store data, rd} and ctrl = {RegWrite, MemToReg, MemRead, MemWrite}.

Parameters:
DATA_W, 69, width of the datapath payload (32+32+5 for the EX/MEM use).
CTRL_W, 4, width of the control payload; masked to zero when the stage is empty.
SKID, 1, 1 = two entries (main + skid) with a registered in_ready_o; 0 = single entry with a combinational in_ready_o.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous reset, active low.
flush_i  in  1  synchronous kill of all held entries.
in_valid_i  in  1  upstream presents a payload.
in_ready_o  out  1  stage can accept this cycle.
in_ctrl_i  in  CTRL_W  upstream control bits.
in_data_i  in  DATA_W  upstream data bits.
out_valid_o  out  1  main entry holds a payload.
out_ready_i  in  1  downstream consumes this cycle; drive with !MemStall.
out_ctrl_o  out  CTRL_W  main control, ANDed with out_valid_o.
out_data_o  out  DATA_W  main data, raw register value.
occupancy_o  out  2  number of held entries: 0, 1 or 2.

Behaviour:
- Reset (async, rst_i=0):
  - both valid bits cleared; all ctrl/data registers cleared to 0.
  - outputs: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0; in_ready_o=1 in both SKID modes.
- Transfers: acc = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. Both are evaluated on the same edge.
- Latency: an accepted payload appears on out_* in the next cycle.
- SKID=1 state machine, S = {EMPTY, ONE, TWO}:
  - EMPTY: acc -> ONE; main <= in.
  - ONE, acc & pop -> ONE; main <= in.
  - ONE, acc & !pop -> TWO; skid <= in.
  - ONE, !acc & pop -> EMPTY.
  - ONE, !acc & !pop -> hold.
  - TWO, pop -> ONE; main <= skid. acc is impossible because in_ready_o=0.
  - TWO, !pop -> hold.
  - in_ready_o = (S != TWO). This is a pure register output with no combinational path from out_ready_i.
- SKID=0:
  - the skid entry is not instantiated.
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - occupancy_o never exceeds 1.
- Flush:
  - flush_i=1 forces S=EMPTY at the edge, whatever acc or pop would have done. It has priority over same-cycle acceptance, so the upstream payload is dropped.
  - data and ctrl registers keep their values but are masked, so out_ctrl_o=0.
  - in_ready_o during a flush cycle follows the pre-flush state.
- Bubble masking: out_ctrl_o = main_ctrl & {CTRL_W{out_valid_o}}. An empty stage can never assert a write-enable.
- Hold: with no acc and no pop, all registers are unchanged. This is the legacy stall behaviour.
- occupancy_o: EMPTY=0, ONE=1, TWO=2, registered.
- No payload is ever duplicated or lost except by flush_i.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

Decomposition:
- Shared package pipe_pkg:
  - control bit indices CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3.
  - EX_MEM_DATA_W=69.
  - stage-state enum {EMPTY, ONE, TWO}.
- One natural sub-module: pipe_slot, a valid + ctrl + data register entry with load/clear, instantiated once for main and once for skid (skid only when SKID=1).

Test Plan:
- Reset: hold rst_i=0, drive in_valid_i=1 with ctrl=4'hF -> out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1; release -> the first accepted payload appears one cycle later.
- Streaming, SKID=1, out_ready_i=1: push data 1..8 on consecutive cycles -> outputs 1..8 on consecutive cycles, each one cycle after input; occupancy_o stays 1; in_ready_o stays 1.
- Backpressure, SKID=1: out_ready_i=0, push A, B, C -> A and B held, occupancy_o=2, in_ready_o=0, C not accepted. Raise out_ready_i -> A, then B, then C in order, none lost.
- Flush priority: occupancy 2 with ctrl=4'b1001 in main; flush_i=1 together with a valid input -> next cycle occupancy_o=0, out_ctrl_o=0, input dropped.
- SKID=0 stall: out_ready_i=0 with main full -> in_ready_o=0 in the same cycle, registers hold; out_ready_i=1 with in_valid_i=1 -> replaced in one cycle.
- Async reset mid-stream: pulse rst_i low between edges while occupancy_o=2 -> out_valid_o and occupancy_o go to 0 immediately, before the next edge.
